// File: rtl/pong_vga_render.sv
// rtl/pong_vga_render.sv - 640x480 VGA timing generator and Pong scene renderer
//
// Purpose: scans an 800x525 raster, produces active-low hsync/vsync and a
// 2-bit-per-channel colour for a ball, a left-edge paddle and (optionally) a
// screen border. Object positions are captured once per frame, at the last
// visible pixel, so a frame is never drawn with mixed positions.
//
// Optional feature: define PONG_BORDER_EN to draw a 1-pixel blue border
// around the visible area.
//
// Ports:
//   clk        - pixel clock
//   rst_n      - asynchronous active-low reset
//   ball_x     - ball left edge (game-logic stage)
//   ball_y     - ball top edge (game-logic stage)
//   paddle_y   - paddle top edge; paddle sits at the left screen edge
//   hsync      - active-low horizontal sync (registered)
//   vsync      - active-low vertical sync (registered)
//   r, g, b    - pixel colour, 2 bits each (registered)
//   frame_tick - one-cycle pulse after the last visible pixel of each frame

module pong_vga_render #(
    parameter int BALL_SIZE     = 10,
    parameter int PADDLE_WIDTH  = 10,
    parameter int PADDLE_HEIGHT = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_y,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       frame_tick
);

    localparam logic [9:0] H_LAST     = 10'd799;
    localparam logic [9:0] V_LAST     = 10'd524;
    localparam logic [9:0] H_VIS_LAST = 10'd639;
    localparam logic [9:0] V_VIS_LAST = 10'd479;
    localparam logic [9:0] HS_START   = 10'd656;
    localparam logic [9:0] HS_END     = 10'd751;
    localparam logic [9:0] VS_START   = 10'd490;
    localparam logic [9:0] VS_END     = 10'd491;

    localparam logic [10:0] BALL_SPAN   = 11'(BALL_SIZE - 1);
    localparam logic [10:0] PADDLE_SPAN = 11'(PADDLE_HEIGHT - 1);
    localparam logic [9:0]  PADDLE_LAST = 10'(PADDLE_WIDTH - 1);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic [9:0] lbx_q, lbx_d;
    logic [9:0] lby_q, lby_d;
    logic [9:0] lpy_q, lpy_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [5:0] rgb_q, rgb_d;
    logic       frame_tick_q, frame_tick_d;

    logic frame_end;
    logic visible;
    logic ball_hit;
    logic paddle_hit;
    logic border_hit;

    always_comb begin
        h_d          = h_q;
        v_d          = v_q;
        lbx_d        = lbx_q;
        lby_d        = lby_q;
        lpy_d        = lpy_q;
        hsync_d      = 1'b1;
        vsync_d      = 1'b1;
        rgb_d        = 6'd0;
        frame_tick_d = 1'b0;
        frame_end    = (h_q == H_VIS_LAST) && (v_q == V_VIS_LAST);
        visible      = (h_q <= H_VIS_LAST) && (v_q <= V_VIS_LAST);

        if (h_q == H_LAST) begin
            h_d = 10'd0;
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 10'd1;
        end

        // Positions captured at the last visible pixel; that pixel itself
        // is still drawn from the previous frame's values.
        if (frame_end) begin
            lbx_d = ball_x;
            lby_d = ball_y;
            lpy_d = paddle_y;
        end
        frame_tick_d = frame_end;

        // 11-bit upper bounds keep objects near 1023 from wrapping to 0.
        ball_hit   = ({1'b0, h_q} >= {1'b0, lbx_q}) &&
                     ({1'b0, h_q} <= {1'b0, lbx_q} + BALL_SPAN) &&
                     ({1'b0, v_q} >= {1'b0, lby_q}) &&
                     ({1'b0, v_q} <= {1'b0, lby_q} + BALL_SPAN);
        paddle_hit = (h_q <= PADDLE_LAST) &&
                     ({1'b0, v_q} >= {1'b0, lpy_q}) &&
                     ({1'b0, v_q} <= {1'b0, lpy_q} + PADDLE_SPAN);
`ifdef PONG_BORDER_EN
        border_hit = (h_q == 10'd0) || (h_q == H_VIS_LAST) ||
                     (v_q == 10'd0) || (v_q == V_VIS_LAST);
`else
        border_hit = 1'b0;
`endif

        hsync_d = !((h_q >= HS_START) && (h_q <= HS_END));
        vsync_d = !((v_q >= VS_START) && (v_q <= VS_END));

        // Off-screen parts of objects fall outside 'visible' and are clipped.
        if (visible) begin
            if (ball_hit) begin
                rgb_d = 6'b11_11_11;
            end else if (paddle_hit) begin
                rgb_d = 6'b00_11_00;
            end else if (border_hit) begin
                rgb_d = 6'b00_00_11;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q          <= 10'd0;
            v_q          <= 10'd0;
            lbx_q        <= 10'd0;
            lby_q        <= 10'd0;
            lpy_q        <= 10'd0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            rgb_q        <= 6'd0;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            lbx_q        <= lbx_d;
            lby_q        <= lby_d;
            lpy_q        <= lpy_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign r          = rgb_q[5:4];
    assign g          = rgb_q[3:2];
    assign b          = rgb_q[1:0];
    assign frame_tick = frame_tick_q;

endmodule
